// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA frame reader.
// Word size and default 640x480 frame geometry.
package vga_pkg;

  localparam int WORD_BYTES = 4;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int DEF_FRAME_WORDS = FRAME_W * FRAME_H;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// First-word-fall-through pixel FIFO with occupancy count.
// Pops on empty and pushes on full are ignored; flush empties it.
module vga_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  assign head  = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + (AW+1)'(do_push)
                         - (AW+1)'(do_pop);
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Avalon-MM frame fetcher feeding a pixel FIFO.
// Reads are throttled by FIFO space and a latency credit.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_start,
  input  logic [31:0] frame_buffer_base_address,
  input  logic [7:0]  memory_latency,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic        master_waitrequest,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic [31:0] pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          read_q, read_d;
  logic [7:0]    lat_q, lat_d;
  logic [31:0]   issued_q, issued_d;
  logic [31:0]   returned_q, returned_d;
  logic [CW-1:0] out_q, out_d;
  logic          aborted_q, aborted_d;

  logic          accept;
  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] out_n;
  logic [CW-1:0] cnt_n;
  logic [31:0]   issued_n;
  logic [7:0]    lat_eff;
  logic          room;
  logic          credit;
  logic          more;

  assign accept = read_q && !master_waitrequest;
  // data with nothing outstanding is stale (e.g. from before reset)
  assign push = master_readdatavalid && (out_q != '0);
  assign pop  = pixel_valid && pixel_ready;

  assign out_n    = out_q + CW'(accept) - CW'(push);
  assign cnt_n    = fifo_count + CW'(push) - CW'(pop);
  assign issued_n = issued_q + 32'(accept);
  assign lat_eff  = (lat_q == 8'd0) ? 8'd1 : lat_q;

  assign room   = (32'(out_n) + 32'(cnt_n) + 32'd1)
                  <= 32'(FIFO_DEPTH);
  assign credit = 32'(out_n) < 32'(lat_eff);
  assign more   = issued_n < 32'(FRAME_WORDS);

  assign master_address = addr_q;
  assign master_read    = read_q;
  assign frame_done     = push &&
    (returned_q == 32'(FRAME_WORDS - 1));

  // state and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      read_q     <= 1'b0;
      lat_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      out_q      <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      lat_q      <= lat_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      out_q      <= out_d;
      aborted_q  <= aborted_d;
    end
  end

  // next-state, request generation and frame sequencing
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    read_d     = read_q;
    lat_d      = lat_q;
    issued_d   = issued_q;
    returned_d = returned_q + 32'(push);
    out_d      = out_n;
    aborted_d  = aborted_q;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        read_d = 1'b0;
        if (vga_start) begin
          addr_d     = frame_buffer_base_address;
          lat_d      = memory_latency;
          issued_d   = '0;
          returned_d = '0;
          aborted_d  = 1'b0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (accept) begin
          addr_d   = addr_q + 32'(WORD_BYTES);
          issued_d = issued_n;
        end
        if (read_q && master_waitrequest) begin
          read_d = 1'b1;
        end else if (accept &&
                     issued_n == 32'(FRAME_WORDS)) begin
          read_d    = 1'b0;
          aborted_d = 1'b0;
          state_d   = DRAIN;
        end else if (!vga_start) begin
          read_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          read_d = room && credit && more;
        end
      end
      DRAIN: begin
        read_d = 1'b0;
        if (out_q == '0) begin
          if (vga_start) begin
            addr_d     = frame_buffer_base_address;
            lat_d      = memory_latency;
            issued_d   = '0;
            returned_d = '0;
            aborted_d  = 1'b0;
            state_d    = FETCH;
          end else begin
            flush   = aborted_q;
            state_d = IDLE;
          end
        end
      end
      default: begin
        read_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  vga_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (master_readdata),
    .pop       (pop),
    .head      (pixel_data),
    .valid     (pixel_valid),
    .count     (fifo_count)
  );

endmodule
